seg_scan_controller: RTL and testbench
======================================

# seg_scan_controller

Time-multiplexed scan controller for the 8-digit, common-anode seven-segment display. It holds one hex nibble and one decimal-point bit per digit in a register file that a host loads through a simple write port. It sequences the shared segment bus across the eight anodes with a blanking gap between digits to suppress ghosting. It sits between user logic and the board's `a..g`, `dp` and `AN[7:0]` pins, and all pins are active-low.

## Interface
- `DRIVE_CYCLES`, default 100000: clock cycles each digit is driven. Must be ≥1.
- `BLANK_CYCLES`, default 1000: clock cycles all anodes are off before each digit. Must be ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, active-low, asynchronous assert. One clock; reset is asynchronous and active-low.
- `wr_en`  in  1  write strobe, sampled on the rising edge of `clk`.
- `wr_addr`  in  3  digit index to write; 0 is the rightmost digit (`AN[0]`).
- `wr_data`  in  4  hex nibble to store.
- `wr_dp`  in  1  decimal-point bit to store; 1 means lit.
- `digit_en`  in  8  per-digit enable; 0 means the digit is blanked but still keeps its time slot.
- `seg`  out  7  `{a,b,c,d,e,f,g}`, with `a` as the MSB; active-low.
- `dp`  out  1  decimal point, active-low.
- `AN`  out  8  anode selects, active-low, one-hot-low when driving.

## Operation
- **Register file:** `digit[0..7]` (4 bits each) and `dpbit[0..7]`.
  - When `wr_en=1`, the edge loads `digit[wr_addr]<=wr_data` and `dpbit[wr_addr]<=wr_dp`.
  - A write is accepted every cycle; there is no backpressure.
- **FSM states:** `BLANK` and `DRIVE`. A cycle counter `cnt` has width `$clog2(max(DRIVE_CYCLES,BLANK_CYCLES))`. A scan index `idx` is 3 bits.
- **`BLANK` state:**
  - Outputs are `AN=8'hFF`, `seg=7'h7F`, `dp=1`.
  - When `cnt==BLANK_CYCLES-1`, the FSM goes to `DRIVE` and `cnt<=0`; otherwise `cnt++`.
- **`DRIVE` state:**
  - When `digit_en[idx]=1`:
    - `AN` is all ones except `AN[idx]=0`.
    - `seg=glyph(digit[idx])`.
    - `dp=~dpbit[idx]`.
  - When `digit_en[idx]=0`, outputs are the same as `BLANK`.
  - When `cnt==DRIVE_CYCLES-1`, the FSM goes to `BLANK`, `cnt<=0`, and `idx<=idx+1`. `idx` wraps from 7 to 0.
- **Glyph table** (active-low, `abcdefg`):
  - 0=`0000001`, 1=`1001111`, 2=`0010010`, 3=`0000110`
  - 4=`1001100`, 5=`0100100`, 6=`0100000`, 7=`0001111`
  - 8=`0000000`, 9=`0000100`, A=`0001000`, b=`1100000`
  - C=`0110001`, d=`1000010`, E=`0110000`, F=`0111000`
- `seg`, `dp` and `AN` are registers; there is no combinational path from the inputs to the outputs.
- `digit_en` is sampled every cycle. Changing it mid-slot takes effect on the next edge.

## Timing
- **Reset (`rst_n=0`, asynchronous):**
  - `state=BLANK`, `cnt=0`, `idx=0`.
  - All `digit` and `dpbit` = 0.
  - `AN=8'hFF`, `seg=7'h7F`, `dp=1`.
  - Reset asserted mid-scan blanks the outputs immediately, with no wait for a clock edge.
- **After reset release:** `AN=8'hFE` appears exactly `BLANK_CYCLES` rising edges after the first edge with `rst_n=1`.
- **Frame period:** 8×(`BLANK_CYCLES`+`DRIVE_CYCLES`) cycles. Every digit gets an equal `DRIVE` slot whether it is enabled or not.
- **Write latency:**
  - `digit` and `dpbit` update on the write edge.
  - If the written index is currently driven, `seg` and `dp` reflect the new value on the following edge (1-cycle latency).
  - Otherwise the new value appears when that digit's slot next begins.
- **Write on the edge entering `DRIVE` for the same index:** the first `DRIVE` cycle shows the old value and the second shows the new one. This single-cycle glitch is accepted.
- **Two writes to the same address on consecutive cycles:** the last write wins.
- **`AN` invariant:** at most one `AN` bit is low at any time. `AN` is never low during `BLANK`.

## Test plan
All scenarios use `DRIVE_CYCLES=4` and `BLANK_CYCLES=2`.
1. **Reset:** assert `rst_n=0` asynchronously mid-`DRIVE` → within the same cycle `AN=FF`, `seg=7F`, `dp=1`. After release, 2 edges later `AN=FE` and `seg=0000001` (digit 0 reset value 0).
2. **Full scan:** write digits 0..7 = 0,1,...,7 with `dpbit[3]=1` and `digit_en=FF` → `AN` steps FE, FD, FB, ..., 7F, each low for exactly 4 cycles and separated by 2-cycle FF gaps. Glyphs match the table. `dp=0` only while `AN=F7`. The frame repeats every 48 cycles.
3. **Hex glyphs:** write A..F into digits 2..7 → `seg` shows `0001000`, `1100000`, `0110001`, `1000010`, `0110000`, `0111000` in the corresponding slots.
4. **Blanking mask:** `digit_en=8'b1010_1010` → `AN` is never FE, FB, EF or BF. Slots 0, 2, 4 and 6 still occupy 4 cycles each with `AN=FF`, so the frame stays 48 cycles.
5. **Live write:** while `AN=FD`, write 9 to address 1 → the next cycle shows `seg=0000100` with `AN` unchanged and the slot length unchanged.
6. **Wrap:** run 3 frames → `idx` wraps 7→0 with no extra cycle, and the one-low-`AN` invariant holds every cycle.

Source files
------------

// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. A host loads one hex nibble and one decimal-point bit per digit
// through a simple write port. The controller walks the shared segment bus
// across the eight anodes. Before each digit it inserts a blanking gap with
// every anode off, which suppresses ghosting between neighbouring digits.
//
// Parameters:
//   DRIVE_CYCLES  clock cycles each digit is driven (>= 1)
//   BLANK_CYCLES  clock cycles all anodes are off before each digit (>= 1)
//
// Ports (all display pins active-low):
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   wr_en     in   write strobe
//   wr_addr   in   [2:0] digit index to write (0 = rightmost, AN[0])
//   wr_data   in   [3:0] hex nibble to store
//   wr_dp     in   decimal-point bit to store (1 = lit)
//   digit_en  in   [7:0] per-digit enable; a disabled digit keeps its slot blank
//   seg       out  [6:0] {a,b,c,d,e,f,g}, a is the MSB
//   dp        out  decimal point
//   AN        out  [7:0] anode selects, one-hot-low while a digit is driven
// -----------------------------------------------------------------------------
module seg_scan_controller #(
  parameter int DRIVE_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [7:0] digit_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] AN
);

  // The counter must hold the larger of the two terminal counts. It is at
  // least one bit wide, so the degenerate 1/1 configuration still elaborates.
  localparam int MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  // Active-low glyph for one hex nibble, segment order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  logic [3:0]       digit_q [8];
  logic [7:0]       dpbit_q;

  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  // Register file: one write per cycle, and the last write to an address wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= 4'h0;
      end
      dpbit_q <= 8'h00;
    end else if (wr_en) begin
      digit_q[wr_addr] <= wr_data;
      dpbit_q[wr_addr] <= wr_dp;
    end
  end

  // Scan state register: FSM state, slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: BLANK -> DRIVE -> BLANK. The index advances as each
  // drive slot ends and wraps naturally from 7 to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = S_BLANK;
          cnt_d   = CNT_ZERO;
          idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = CNT_ZERO;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Output decode. It works from the next state and index, so the registered
  // pins line up with the state that the same edge enters. It reads the stored
  // digit before this edge's write lands, which gives a written value one
  // cycle of latency on the pins.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((state_d == S_DRIVE) && digit_en[idx_d]) begin
      an_d  = ~(8'h01 << idx_d);
      seg_d = glyph(digit_q[idx_d]);
      dp_d  = ~dpbit_q[idx_d];
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // Output registers. Reset blanks the pins at once, without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign AN  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

  localparam int D = 4;
  localparam int B = 2;
  localparam int P = B + D;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic [7:0] digit_en;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] AN;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [3:0] m_digit [8];
  logic       m_dp    [8];
  logic [6:0] glyph_tbl [16];
  int         n;          // rising edges since reset release
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  seg_scan_controller #(.DRIVE_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .digit_en(digit_en),
    .seg(seg), .dp(dp), .AN(AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_digit[i] = 4'h0;
      m_dp[i]    = 1'b0;
    end
    n = 0;
  endtask

  // Advance one edge. Position in the frame is computed arithmetically from the
  // edge count: each slot is B blank cycles followed by D drive cycles.
  task automatic step();
    int u;
    int slot;
    logic [7:0] one;
    @(posedge clk);
    n++;
    u    = n % P;
    slot = (n % (8 * P)) / P;
    one  = 8'h01;
    if (u >= B && digit_en[slot]) begin
      exp_an  = ~(one << slot);
      exp_seg = glyph_tbl[m_digit[slot]];
      exp_dp  = ~m_dp[slot];
    end else begin
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end
    if (wr_en) begin
      m_digit[wr_addr] = wr_data;
      m_dp[wr_addr]    = wr_dp;
    end
    #1;
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int guard;
    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    model_clear();
    step();
    tests_run++;
    if ({AN, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_first_edge: got AN=%h seg=%b dp=%b want AN=ff seg=1111111 dp=1", AN, seg, dp);
    end
    step();
    tests_run++;
    if ({AN, seg, dp} !== {8'hFE, 7'b0000001, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_first_digit: got AN=%h seg=%b dp=%b want AN=fe seg=0000001 dp=1", AN, seg, dp);
    end
    // Assert reset mid-drive: outputs must blank without a clock edge.
    write_digit(3'd1, 4'h8, 1'b1);
    guard = 0;
    while (exp_an == 8'hFF && guard < 50) begin
      step();
      guard++;
    end
    tests_run++;
    if (guard >= 50) begin
      tests_failed++;
      $display("FAIL reset_wait_drive: no drive slot seen within 50 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({AN, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_async: got AN=%h seg=%b dp=%b want AN=ff seg=1111111 dp=1", AN, seg, dp);
    end
    #3 rst_n = 1'b1;
    model_clear();
    step();
    step();
    tests_run++;
    if ({AN, seg, dp} !== {8'hFE, 7'b0000001, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_rerelease: got AN=%h seg=%b dp=%b want AN=fe seg=0000001 dp=1", AN, seg, dp);
    end
  endtask

  task automatic test_full_scan();
    logic [15:0] frame [P * 8];
    int dp_low;
    int dp_bad;
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i), (i == 3));
    // Let any slot drawn with pre-write contents pass.
    for (int i = 0; i < 8 * P; i++) step();
    dp_low = 0;
    dp_bad = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8 * P; i++) begin
        step();
        tests_run++;
        if ({AN, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
          tests_failed++;
          $display("FAIL full_scan n=%0d: got AN=%h seg=%b dp=%b want AN=%h seg=%b dp=%b",
                   n, AN, seg, dp, exp_an, exp_seg, exp_dp);
        end
        if (f == 0) begin
          frame[i] = {AN, seg, dp};
          if (dp == 1'b0) begin
            dp_low++;
            if (AN != 8'hF7) dp_bad++;
          end
        end else begin
          tests_run++;
          if ({AN, seg, dp} !== frame[i]) begin
            tests_failed++;
            $display("FAIL frame_repeat i=%0d: got %h want %h", i, {AN, seg, dp}, frame[i]);
          end
        end
      end
    end
    tests_run++;
    if (dp_low != D || dp_bad != 0) begin
      tests_failed++;
      $display("FAIL dp_only_digit3: got low=%0d misplaced=%0d want low=%0d misplaced=0", dp_low, dp_bad, D);
    end
  endtask

  task automatic test_hex_glyphs();
    for (int i = 2; i < 8; i++) write_digit(3'(i), 4'(i + 8), 1'b0);
    for (int i = 0; i < 8 * P; i++) step();
    for (int i = 0; i < 8 * P; i++) begin
      step();
      tests_run++;
      if ({AN, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        tests_failed++;
        $display("FAIL hex_glyphs n=%0d: got AN=%h seg=%b want AN=%h seg=%b", n, AN, seg, exp_an, exp_seg);
      end
      if (AN == 8'h7F) begin
        tests_run++;
        if (seg !== 7'b0111000) begin
          tests_failed++;
          $display("FAIL hex_F: got seg=%b want 0111000", seg);
        end
      end
    end
  endtask

  task automatic test_blank_mask();
    int ff_cnt;
    digit_en = 8'b1010_1010;
    step();
    ff_cnt = 0;
    for (int i = 0; i < 8 * P; i++) begin
      step();
      tests_run++;
      if ({AN, seg, dp} !== {exp_an, exp_seg, exp_dp} ||
          AN == 8'hFE || AN == 8'hFB || AN == 8'hEF || AN == 8'hBF) begin
        tests_failed++;
        $display("FAIL blank_mask n=%0d: got AN=%h seg=%b want AN=%h seg=%b", n, AN, seg, exp_an, exp_seg);
      end
      if (AN == 8'hFF) ff_cnt++;
    end
    tests_run++;
    if (ff_cnt != 8 * B + 4 * D) begin
      tests_failed++;
      $display("FAIL blank_mask_count: got %0d blank cycles want %0d", ff_cnt, 8 * B + 4 * D);
    end
    digit_en = 8'hFF;
  endtask

  task automatic test_live_write();
    int guard;
    guard = 0;
    while (exp_an != 8'hFF && guard < 100) begin step(); guard++; end
    while (exp_an != 8'hFD && guard < 100) begin step(); guard++; end
    tests_run++;
    if (guard >= 100 || AN !== 8'hFD) begin
      tests_failed++;
      $display("FAIL live_wait: got AN=%h after %0d cycles want fd", AN, guard);
    end
    write_digit(3'd1, 4'h9, 1'b0);
    step();
    tests_run++;
    if ({AN, seg} !== {8'hFD, 7'b0000100}) begin
      tests_failed++;
      $display("FAIL live_write: got AN=%h seg=%b want AN=fd seg=0000100", AN, seg);
    end
    step();
    tests_run++;
    if (AN !== 8'hFD) begin
      tests_failed++;
      $display("FAIL live_slot_len: got AN=%h want fd on 4th drive cycle", AN);
    end
    step();
    tests_run++;
    if (AN !== 8'hFF) begin
      tests_failed++;
      $display("FAIL live_slot_end: got AN=%h want ff after 4 drive cycles", AN);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      wr_dp   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom_range(0, 255));
      step();
      tests_run++;
      if ({AN, seg, dp} !== {exp_an, exp_seg, exp_dp} || $countones(~AN) > 1) begin
        tests_failed++;
        $display("FAIL random n=%0d: got AN=%h seg=%b dp=%b want AN=%h seg=%b dp=%b",
                 n, AN, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    wr_en = 1'b0;
    digit_en = 8'hFF;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3 * 8 * P; i++) begin
      step();
      tests_run++;
      if ({AN, seg, dp} !== {exp_an, exp_seg, exp_dp} || $countones(~AN) > 1) begin
        tests_failed++;
        $display("FAIL wrap n=%0d: got AN=%h seg=%b dp=%b want AN=%h seg=%b dp=%b",
                 n, AN, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    glyph_tbl[0]  = 7'b0000001; glyph_tbl[1]  = 7'b1001111;
    glyph_tbl[2]  = 7'b0010010; glyph_tbl[3]  = 7'b0000110;
    glyph_tbl[4]  = 7'b1001100; glyph_tbl[5]  = 7'b0100100;
    glyph_tbl[6]  = 7'b0100000; glyph_tbl[7]  = 7'b0001111;
    glyph_tbl[8]  = 7'b0000000; glyph_tbl[9]  = 7'b0000100;
    glyph_tbl[10] = 7'b0001000; glyph_tbl[11] = 7'b1100000;
    glyph_tbl[12] = 7'b0110001; glyph_tbl[13] = 7'b1000010;
    glyph_tbl[14] = 7'b0110000; glyph_tbl[15] = 7'b0111000;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0; wr_dp = 1'b0;
    digit_en = 8'hFF;
    exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
    model_clear();
    test_reset();
    test_full_scan();
    test_hex_glyphs();
    test_blank_mask();
    test_live_write();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
